// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issue controller.
//   OP_*        : fpu opcode encodings
//   EXP_MAX     : all-ones exponent (inf / nan)
//   EXP_BIAS    : single-precision exponent bias
//   fp_flags_t  : result class flags {nan, inf, zero, denorm}
//   fp_classify : derive the class flags from a single-precision word
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam int         EXP_BIAS = 127;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic denorm;
  } fp_flags_t;

  // At most one flag can be set: the four cases partition on (e, m).
  function automatic fp_flags_t fp_classify(input logic [31:0] i_x);
    logic [7:0]  w_e;
    logic [22:0] w_m;
    fp_flags_t   w_f;
    w_e        = i_x[30:23];
    w_m        = i_x[22:0];
    w_f.nan    = (w_e == EXP_MAX) && (w_m != '0);
    w_f.inf    = (w_e == EXP_MAX) && (w_m == '0);
    w_f.zero   = (w_e == '0)      && (w_m == '0);
    w_f.denorm = (w_e == '0)      && (w_m != '0);
    return w_f;
  endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Synchronous response FIFO.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_push/i_push_data : write an entry
//   i_pop            : release the head entry
//   o_pop_data       : head entry (valid while !o_empty)
//   o_full, o_empty  : occupancy status
//   o_count          : number of stored entries
// Push and pop may coincide, including when full (pop frees the slot) and
// when empty (no bypass: pushed data becomes visible the next cycle).
module fpu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_pop_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Initiator-side controller for the single-precision fpu.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake; req_a/req_b/req_op/req_tag payload
//   fpu_a/fpu_b/fpu_opcode   : registered operands/opcode to the fpu
//   fpu_o                    : fpu result, captured LAT cycles after issue
//   rsp_valid/rsp_ready      : response handshake; rsp_data/rsp_op/rsp_tag/rsp_flags payload
//   busy                     : operations in flight or buffered
// Credits: an issue is only accepted when in-flight plus buffered results
// leave a free FIFO slot, so every captured result always has room.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT       = 2,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_opcode,
  input  logic [31:0]      fpu_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [1:0]       rsp_op,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  localparam int CNT_W = $clog2(RES_DEPTH) + 1;
  localparam int SUM_W = $clog2(RES_DEPTH + LAT + 1);
  localparam int ENT_W = 4 + 2 + TAG_W + 32;

  logic [LAT-1:0]   r_pipe_vld;
  logic [1:0]       r_pipe_op  [LAT];
  logic [TAG_W-1:0] r_pipe_tag [LAT];

  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_push_ent;
  logic [ENT_W-1:0] w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [SUM_W-1:0] w_inflight;
  logic [SUM_W-1:0] w_occupancy;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + SUM_W'(r_pipe_vld[i]);
    end
  end

  assign w_occupancy = w_inflight + SUM_W'(w_fifo_count);
  // Depends only on registered state and rst, never on req_valid/rsp_ready.
  assign req_ready   = !rst && (w_occupancy < SUM_W'(RES_DEPTH));
  assign w_issue     = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_opcode <= OP_ADD;
    end else begin
      r_pipe_vld[0] <= w_issue;
      for (int i = 1; i < LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
      // Without an issue the operands simply hold; the fpu may recompute
      // them but the result is ignored since no valid bit follows it.
      if (w_issue) begin
        fpu_a      <= req_a;
        fpu_b      <= req_b;
        fpu_opcode <= req_op;
      end
    end
  end

  // Op/tag sidebands are qualified by r_pipe_vld and need no reset.
  always_ff @(posedge clk) begin
    r_pipe_op[0]  <= req_op;
    r_pipe_tag[0] <= req_tag;
    for (int i = 1; i < LAT; i++) begin
      r_pipe_op[i]  <= r_pipe_op[i-1];
      r_pipe_tag[i] <= r_pipe_tag[i-1];
    end
  end

  assign w_push     = r_pipe_vld[LAT-1];
  assign w_push_ent = {fp_classify(fpu_o), r_pipe_op[LAT-1], r_pipe_tag[LAT-1], fpu_o};
  assign w_pop      = rsp_valid && rsp_ready;

  fpu_rsp_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (ENT_W)
  ) u_rsp_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (w_push),
    .i_push_data (w_push_ent),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  assign {rsp_flags, rsp_op, rsp_tag, rsp_data} = w_head;
  assign rsp_valid = !w_fifo_empty;
  assign busy      = (w_inflight != '0) || !w_fifo_empty;

  // The credit rule must make a push into a full FIFO impossible unless
  // the head leaves on the same edge.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_push |-> (!w_fifo_full || w_pop));

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

  localparam int LAT       = 2;
  localparam int RES_DEPTH = 4;
  localparam int TAG_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [1:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_opcode;
  logic [31:0]      fpu_o;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [1:0]       rsp_op;
  logic [TAG_W-1:0] rsp_tag;
  logic [3:0]       rsp_flags;
  logic             busy;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [3:0]       flags;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } rsp_t;

  rsp_t sb[$];

  fpu_issue_ctrl #(.LAT(LAT), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_opcode (fpu_opcode),
    .fpu_o      (fpu_o),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_tag    (rsp_tag),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural single-precision fpu ----------------
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e11;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != 0) return $bitstoreal(64'h7FF8000000000000);
      return x[31] ? $bitstoreal(64'hFFF0000000000000) : $bitstoreal(64'h7FF0000000000000);
    end
    if (x[30:23] == 8'h00) return x[31] ? -0.0 : 0.0;
    e11 = 11'(int'(x[30:23]) + 896);
    return $bitstoreal({x[31], e11, x[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 2047) return (d[51:0] != 0) ? {d[63], 8'hFF, 23'h400000} : {d[63], 8'hFF, 23'h0};
    if (e == 0) return {d[63], 31'h0};
    e = e - 1023 + 127;
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0) return {d[63], 31'h0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    real ra, rb, r;
    ra = sp2r(a);
    rb = sp2r(b);
    case (op)
      2'b00:   r = ra + rb;
      2'b01:   r = ra - rb;
      2'b10:   r = ra / rb;
      default: r = ra * rb;
    endcase
    return r2sp(r);
  endfunction

  // The fpu registers its result one edge after its operands are registered;
  // together with the operand register this gives the controller's LAT of 2.
  always @(posedge clk) fpu_o <= fpu_fn(fpu_a, fpu_b, fpu_opcode);

  // ---------------- reference model ----------------
  function automatic logic [3:0] classify(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] m;
    e = x[30:23];
    m = x[22:0];
    if (e == 8'hFF) return (m != 0) ? 4'b1000 : 4'b0100;
    if (e == 8'h00) return (m == 0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
  endfunction

  function automatic rsp_t expect_rsp(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op, input logic [TAG_W-1:0] tag);
    rsp_t r;
    r.data  = fpu_fn(a, b, op);
    r.op    = op;
    r.tag   = tag;
    r.flags = classify(r.data);
    return r;
  endfunction

  function automatic logic [31:0] gen_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h7FC00000;
      1:       return 32'h7F800000;
      2:       return 32'h00000000;
      3:       return 32'h3F800000;
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
    endcase
  endfunction

  function automatic rsp_t cur_rsp();
    return {rsp_flags, rsp_op, rsp_tag, rsp_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [TAG_W-1:0] tag);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive_req(1'b1, 32'h3F800000, 32'h3F800000, 2'b11, 4'd1);
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready_low got %b want 0", req_ready);
    else passes++;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy} !== 3'b100)
      $display("FAIL reset_status got ready=%b rsp_valid=%b busy=%b want 1 0 0", req_ready, rsp_valid, busy);
    else passes++;
    checks++;
    if ({fpu_a, fpu_b, fpu_opcode} !== 66'h0)
      $display("FAIL reset_fpu_regs got a=%h b=%h op=%b want 0 0 00", fpu_a, fpu_b, fpu_opcode);
    else passes++;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    drive_req(1'b1, 32'h3F800000, 32'h40000000, 2'b00, 4'd3);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL single_ready got %b want 1", req_ready);
    else passes++;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({fpu_a, fpu_b, fpu_opcode} !== {32'h3F800000, 32'h40000000, 2'b00})
      $display("FAIL single_fpu_drive got a=%h b=%h op=%b want 3f800000 40000000 00", fpu_a, fpu_b, fpu_opcode);
    else passes++;
    checks++;
    if ({busy, rsp_valid} !== 2'b10) $display("FAIL single_busy got busy=%b rsp_valid=%b want 1 0", busy, rsp_valid);
    else passes++;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL single_early got rsp_valid=%b want 0", rsp_valid);
    else passes++;
    tick();
    checks++;
    if ({rsp_valid, cur_rsp()} !== {1'b1, 4'b0000, 2'b00, 4'd3, 32'h40400000})
      $display("FAIL single_rsp got v=%b data=%h op=%b tag=%0d flags=%b want 1 40400000 00 3 0000",
               rsp_valid, rsp_data, rsp_op, rsp_tag, rsp_flags);
    else passes++;
    tick();
    checks++;
    if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_idle got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    else passes++;
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    drive_req(1'b1, 32'h40000000, 32'h40400000, 2'b11, 4'd5);
    tick();
    drive_req(1'b1, 32'h3F800000, 32'h3F800000, 2'b00, 4'd6);
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, cur_rsp()} !== {1'b1, 4'b0000, 2'b11, 4'd5, 32'h40C00000})
      $display("FAIL b2b_first got v=%b data=%h op=%b tag=%0d flags=%b want 1 40c00000 11 5 0000",
               rsp_valid, rsp_data, rsp_op, rsp_tag, rsp_flags);
    else passes++;
    tick();
    checks++;
    if ({rsp_valid, cur_rsp()} !== {1'b1, 4'b0000, 2'b00, 4'd6, 32'h40000000})
      $display("FAIL b2b_second got v=%b data=%h op=%b tag=%0d flags=%b want 1 40000000 00 6 0000",
               rsp_valid, rsp_data, rsp_op, rsp_tag, rsp_flags);
    else passes++;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL b2b_drained got rsp_valid=%b want 0", rsp_valid);
    else passes++;
  endtask

  task automatic test_classify();
    rsp_ready = 1'b1;
    drive_req(1'b1, 32'h7FC00000, 32'h3F800000, 2'b00, 4'd1);
    tick();
    drive_req(1'b1, 32'h7F800000, 32'h3F800000, 2'b00, 4'd2);
    tick();
    drive_req(1'b1, 32'h3F800000, 32'h3F800000, 2'b01, 4'd4);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({rsp_valid, cur_rsp()} !== {1'b1, 4'b1000, 2'b00, 4'd1, 32'h7FC00000})
      $display("FAIL class_nan got v=%b data=%h flags=%b want 1 7fc00000 1000", rsp_valid, rsp_data, rsp_flags);
    else passes++;
    tick();
    checks++;
    if ({rsp_valid, cur_rsp()} !== {1'b1, 4'b0100, 2'b00, 4'd2, 32'h7F800000})
      $display("FAIL class_inf got v=%b data=%h flags=%b want 1 7f800000 0100", rsp_valid, rsp_data, rsp_flags);
    else passes++;
    tick();
    checks++;
    if ({rsp_valid, cur_rsp()} !== {1'b1, 4'b0010, 2'b01, 4'd4, 32'h00000000})
      $display("FAIL class_zero got v=%b data=%h flags=%b want 1 00000000 0010", rsp_valid, rsp_data, rsp_flags);
    else passes++;
    tick();
  endtask

  task automatic test_backpressure();
    int          issues = 0;
    int          pops = 0;
    int          cyc = 0;
    rsp_t        exp;
    logic [31:0] a, b;
    logic [1:0]  op;
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = gen_operand(); b = gen_operand(); op = 2'($urandom_range(0, 3));
      drive_req(1'b1, a, b, op, TAG_W'(i));
      if (req_ready) begin
        sb.push_back(expect_rsp(a, b, op, TAG_W'(i)));
        issues++;
      end
      tick();
    end
    checks++;
    if (issues != RES_DEPTH) $display("FAIL bp_issue_count got %0d want %0d", issues, RES_DEPTH);
    else passes++;
    checks++;
    if (req_ready !== 1'b0) $display("FAIL bp_ready_low got %b want 0", req_ready);
    else passes++;
    exp = (sb.size() > 0) ? sb[0] : '0;
    checks++;
    if ({rsp_valid, cur_rsp()} !== {1'b1, exp})
      $display("FAIL bp_head got v=%b rsp=%h want 1 %h", rsp_valid, cur_rsp(), exp);
    else passes++;
    tick();
    checks++;
    if ({rsp_valid, cur_rsp()} !== {1'b1, exp})
      $display("FAIL bp_stable got v=%b rsp=%h want 1 %h", rsp_valid, cur_rsp(), exp);
    else passes++;
    // single pop while a request is pending
    rsp_ready = 1'b1;
    a = gen_operand(); b = gen_operand(); op = 2'($urandom_range(0, 3));
    drive_req(1'b1, a, b, op, 4'd10);
    if (rsp_valid && sb.size() > 0) begin
      exp = sb.pop_front();
      pops++;
    end
    if (req_ready) sb.push_back(expect_rsp(a, b, op, 4'd10));
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL bp_credit got req_ready=%b want 1", req_ready);
    else passes++;
    if (req_ready) sb.push_back(expect_rsp(a, b, op, 4'd10));
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (sb.size() > 0 && cyc < 40) begin
      if (rsp_valid) begin
        exp = sb.pop_front();
        pops++;
        checks++;
        if (cur_rsp() !== exp) $display("FAIL bp_drain got %h want %h", cur_rsp(), exp);
        else passes++;
      end
      tick();
      cyc++;
    end
    checks++;
    if ({pops, busy, rsp_valid} !== {RES_DEPTH + 1, 1'b0, 1'b0})
      $display("FAIL bp_total got pops=%0d busy=%b rsp_valid=%b want %0d 0 0", pops, busy, rsp_valid, RES_DEPTH + 1);
    else passes++;
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    rsp_ready = 1'b1;
    drive_req(1'b1, 32'h40000000, 32'h40400000, 2'b11, 4'd7);
    tick();
    drive_req(1'b1, 32'h3F800000, 32'h40000000, 2'b10, 4'd8);
    tick();
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) $display("FAIL midrst_ready_low got %b want 0", req_ready);
    else passes++;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, rsp_valid, fpu_opcode, req_ready} !== 5'b00001)
      $display("FAIL midrst_state got busy=%b rsp_valid=%b op=%b ready=%b want 0 0 00 1",
               busy, rsp_valid, fpu_opcode, req_ready);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || busy) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL midrst_no_rsp got %0d active cycles want 0", seen);
    else passes++;
  endtask

  task automatic test_tag_wrap();
    int          issued = 0;
    int          pops = 0;
    int          cyc = 0;
    rsp_t        exp;
    logic [31:0] a, b;
    logic [1:0]  op;
    while ((issued < 20 || sb.size() > 0) && cyc < 600) begin
      if (issued < 20 && $urandom_range(0, 3) != 0) begin
        a = gen_operand(); b = gen_operand(); op = 2'($urandom_range(0, 3));
        drive_req(1'b1, a, b, op, TAG_W'(issued % 16));
      end else begin
        req_valid = 1'b0;
      end
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid && rsp_ready) begin
        pops++;
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL wrap_extra_rsp got rsp=%h want none", cur_rsp());
        end else begin
          exp = sb.pop_front();
          if (cur_rsp() !== exp) $display("FAIL wrap_rsp got %h want %h", cur_rsp(), exp);
          else passes++;
        end
      end
      if (req_valid && req_ready) begin
        sb.push_back(expect_rsp(req_a, req_b, req_op, req_tag));
        issued++;
      end
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    checks++;
    if ({issued, pops, busy} !== {32'd20, 32'd20, 1'b0})
      $display("FAIL wrap_total got issued=%0d pops=%0d busy=%b want 20 20 0", issued, pops, busy);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive_req(1'b0, 32'h0, 32'h0, 2'b00, '0);
    test_reset();
    test_single();
    test_back_to_back();
    test_classify();
    test_backpressure();
    test_reset_midflight();
    test_tag_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
